// File: rtl/bus_map_pkg.sv
// Address map and register layout shared by the main-bus responder and its console FIFO.
package bus_map_pkg;

    localparam logic [31:0] RAM_BASE_DEFAULT  = 32'h0001_0000;
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0002_0000;

    // Byte offsets within the MMIO page, and the matching word index (address[3:2]).
    localparam logic [3:0] OFS_LED     = 4'h0;
    localparam logic [3:0] OFS_CONSOLE = 4'h4;
    localparam logic [3:0] OFS_CYCLES  = 4'h8;
    localparam logic [3:0] OFS_ERROR   = 4'hC;

    typedef enum logic [1:0] {
        REG_LED     = OFS_LED[3:2],
        REG_CONSOLE = OFS_CONSOLE[3:2],
        REG_CYCLES  = OFS_CYCLES[3:2],
        REG_ERROR   = OFS_ERROR[3:2]
    } mmio_reg_e;

    localparam int CONS_EMPTY_BIT = 0;
    localparam int CONS_FULL_BIT  = 1;
    localparam int CONS_COUNT_LSB = 4;
    localparam int CONS_COUNT_W   = 4;

    function automatic logic [31:0] console_status(input logic [CONS_COUNT_W-1:0] count,
                                                   input logic full, input logic empty);
        logic [31:0] s;
        s = '0;
        s[CONS_COUNT_LSB +: CONS_COUNT_W] = count;
        s[CONS_FULL_BIT]  = full;
        s[CONS_EMPTY_BIT] = empty;
        return s;
    endfunction

endpackage

// File: rtl/bus_ram_responder_if.sv
// Main-bus and console signals between the core side (master) and the responder (slave).
interface bus_ram_responder_if;
    // Bus: an access happens at every edge where an address is nonzero; no handshake.
    // Console: a byte transfers at an edge where console_valid && console_ready; valid
    // never depends on ready, and data/valid hold until that transfer.
    logic [31:0] bus_read_address;
    logic [31:0] bus_read_data;
    logic [31:0] bus_write_address;
    logic [31:0] bus_write_data;
    logic [7:0]  console_data;
    logic        console_valid;
    logic        console_ready;

    modport master (
        output bus_read_address, bus_write_address, bus_write_data, console_ready,
        input  bus_read_data, console_data, console_valid
    );

    modport slave (
        input  bus_read_address, bus_write_address, bus_write_data, console_ready,
        output bus_read_data, console_data, console_valid
    );
endinterface

// File: rtl/console_tx_fifo.sv
// Byte FIFO feeding the console sink; push and pop may coincide even when full.
module console_tx_fifo #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             ready,
    output logic             valid,
    output logic [7:0]       data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;
    logic             push_ok;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign valid    = !empty;
    assign data     = empty ? 8'h00 : mem[rd_ptr];
    assign pop      = valid && ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok  = push && (!full || pop);
    assign overflow = push && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/bus_ram_responder.sv
// Main-bus responder: word RAM window, MMIO page (LED, console, cycle counter, error flag).
module bus_ram_responder
  import bus_map_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] RAM_BASE   = RAM_BASE_DEFAULT,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
  parameter int          FIFO_DEPTH = 4,
  parameter              INIT_FILE  = ""
) (
  input  logic                cpu_clk,
  input  logic                rst,
  bus_ram_responder_if.slave  bus,
  output logic [31:0]         leds_reg,
  output logic                bus_error
);
  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [29:0] RAM_W_LO  = RAM_BASE[31:2];
  localparam logic [29:0] RAM_W_HI  = RAM_W_LO + 30'(RAM_WORDS);
  localparam logic [27:0] MMIO_PAGE = MMIO_BASE[31:4];

  logic [31:0] mem [RAM_WORDS];

  logic [29:0]      rd_word, wr_word;
  logic             rd_en, rd_ram, rd_mmio;
  logic             wr_en, wr_ram, wr_mmio;
  mmio_reg_e        rd_reg, wr_reg;
  logic [IDX_W-1:0] rd_idx, wr_idx;

  assign rd_word = bus.bus_read_address[31:2];
  assign wr_word = bus.bus_write_address[31:2];
  assign rd_en   = (bus.bus_read_address != 32'd0);
  assign wr_en   = (bus.bus_write_address != 32'd0);
  assign rd_ram  = rd_en && (rd_word >= RAM_W_LO) && (rd_word < RAM_W_HI);
  assign wr_ram  = wr_en && (wr_word >= RAM_W_LO) && (wr_word < RAM_W_HI);
  assign rd_mmio = rd_en && (bus.bus_read_address[31:4] == MMIO_PAGE);
  assign wr_mmio = wr_en && (bus.bus_write_address[31:4] == MMIO_PAGE);
  assign rd_reg  = mmio_reg_e'(bus.bus_read_address[3:2]);
  assign wr_reg  = mmio_reg_e'(bus.bus_write_address[3:2]);
  assign rd_idx  = IDX_W'(rd_word - RAM_W_LO);
  assign wr_idx  = IDX_W'(wr_word - RAM_W_LO);

  logic             cons_push, cons_full, cons_empty, cons_overflow;
  logic [CNT_W-1:0] cons_count;

  assign cons_push = wr_mmio && (wr_reg == REG_CONSOLE);

  console_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_console_fifo (
    .clk       (cpu_clk),
    .rst       (rst),
    .push      (cons_push),
    .push_data (bus.bus_write_data[7:0]),
    .ready     (bus.console_ready),
    .valid     (bus.console_valid),
    .data      (bus.console_data),
    .count     (cons_count),
    .full      (cons_full),
    .empty     (cons_empty),
    .overflow  (cons_overflow)
  );

  logic [31:0] cycles;
  logic [31:0] rd_value;
  logic [31:0] rdata_q;
  logic        err_set, err_clear;

  assign err_set   = (rd_en && !rd_ram && !rd_mmio) || (wr_en && !wr_ram && !wr_mmio)
                   || cons_overflow;
  assign err_clear = wr_mmio && (wr_reg == REG_ERROR);

  // All sources are pre-edge state, so a same-edge write is not seen by the read.
  always_comb begin
    rd_value = 32'd0;
    if (rd_ram) begin
      rd_value = mem[rd_idx];
    end else if (rd_mmio) begin
      case (rd_reg)
        REG_LED:     rd_value = leds_reg;
        REG_CONSOLE: rd_value = console_status(CONS_COUNT_W'(cons_count),
                                               cons_full, cons_empty);
        REG_CYCLES:  rd_value = cycles;
        REG_ERROR:   rd_value = {31'd0, bus_error};
        default:     rd_value = 32'd0;
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (wr_ram) mem[wr_idx] <= bus.bus_write_data;
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      rdata_q   <= 32'd0;
      leds_reg  <= 32'd0;
      cycles    <= 32'd0;
      bus_error <= 1'b0;
    end else begin
      if (rd_en) rdata_q <= rd_value;
      if (wr_mmio && (wr_reg == REG_LED)) leds_reg <= bus.bus_write_data;
      if (wr_mmio && (wr_reg == REG_CYCLES)) cycles <= bus.bus_write_data;
      else                                   cycles <= cycles + 32'd1;
      if (err_set)        bus_error <= 1'b1;
      else if (err_clear) bus_error <= 1'b0;
    end
  end

  assign bus.bus_read_data = rdata_q;
endmodule

// File: tb/tb_bus_ram_responder.sv
// Directed bench for bus_ram_responder with queued expectations for reads and console bytes.
module tb_bus_ram_responder;
    logic cpu_clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] leds_reg;
    logic bus_error;

    bus_ram_responder_if bus ();

    bus_ram_responder dut (
        .cpu_clk   (cpu_clk),
        .rst       (rst),
        .bus       (bus),
        .leds_reg  (leds_reg),
        .bus_error (bus_error)
    );

    always #5 cpu_clk = ~cpu_clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  cons_q[$];
    logic        rd_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; monitors look at the falling edge.
    task automatic cycle(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd,
                         input logic [31:0] exp);
        bus.bus_read_address  = ra;
        bus.bus_write_address = wa;
        bus.bus_write_data    = wd;
        if (ra != 32'd0) exp_q.push_back(exp);
        @(posedge cpu_clk);
        #1;
        bus.bus_read_address  = 32'd0;
        bus.bus_write_address = 32'd0;
        bus.bus_write_data    = 32'd0;
    endtask

    task automatic cons_write(input logic [7:0] b, input logic expect_accept);
        if (expect_accept) cons_q.push_back(b);
        cycle(32'd0, 32'h0002_0004, {24'd0, b}, 32'd0);
    endtask

    always @(negedge cpu_clk) begin
        if (rd_pending) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read_data", 32'd1, 32'd0);
            end else begin
                check("read_data", bus.bus_read_data, exp_q.pop_front());
            end
        end
        rd_pending = !rst && (bus.bus_read_address != 32'd0);
        if (!rst && bus.console_valid && bus.console_ready) begin
            if (cons_q.size() == 0) begin
                check("unexpected_console_pop", 32'd1, 32'd0);
            end else begin
                check("console_byte", {24'd0, bus.console_data}, {24'd0, cons_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.bus_read_address  = 32'd0;
        bus.bus_write_address = 32'd0;
        bus.bus_write_data    = 32'd0;
        bus.console_ready     = 1'b0;
        repeat (2) @(posedge cpu_clk);
        #1 rst = 1'b0;

        check("rst_read_data", bus.bus_read_data, 32'd0);
        check("rst_leds", leds_reg, 32'd0);
        check("rst_error", {31'd0, bus_error}, 32'd0);
        check("rst_console_valid", {31'd0, bus.console_valid}, 32'd0);
        check("rst_console_data", {24'd0, bus.console_data}, 32'd0);

        // RAM write then read, including ignored low address bits and window edges
        cycle(32'd0, 32'h0001_0010, 32'hDEAD_BEEF, 32'd0);
        cycle(32'h0001_0010, 32'd0, 32'd0, 32'hDEAD_BEEF);
        check("ram_no_error", {31'd0, bus_error}, 32'd0);
        cycle(32'h0001_0013, 32'd0, 32'd0, 32'hDEAD_BEEF);
        cycle(32'd0, 32'h0001_0FFC, 32'h1234_5678, 32'd0);
        cycle(32'h0001_0FFC, 32'd0, 32'd0, 32'h1234_5678);
        check("ram_top_no_error", {31'd0, bus_error}, 32'd0);

        // same-edge read and write of one word returns the old value
        cycle(32'd0, 32'h0001_0020, 32'h0000_0005, 32'd0);
        cycle(32'h0001_0020, 32'h0001_0020, 32'h0000_0001, 32'h0000_0005);
        cycle(32'h0001_0020, 32'd0, 32'd0, 32'h0000_0001);

        // LED register
        cycle(32'd0, 32'h0002_0000, 32'hA5A5_0F0F, 32'd0);
        check("leds_write", leds_reg, 32'hA5A5_0F0F);
        cycle(32'h0002_0000, 32'd0, 32'd0, 32'hA5A5_0F0F);

        // console overflow with sink stalled
        for (int i = 0; i < 5; i++) cons_write(8'h41 + 8'(i), i < 4);
        check("overflow_error", {31'd0, bus_error}, 32'd1);
        cycle(32'h0002_0004, 32'd0, 32'd0, 32'h0000_0042);
        cycle(32'h0002_000C, 32'd0, 32'd0, 32'h0000_0001);
        cycle(32'd0, 32'h0002_000C, 32'd0, 32'd0);
        check("error_cleared", {31'd0, bus_error}, 32'd0);
        bus.console_ready = 1'b1;
        repeat (4) @(posedge cpu_clk);
        #1;
        check("drained_valid", {31'd0, bus.console_valid}, 32'd0);
        bus.console_ready = 1'b0;
        cycle(32'h0002_0004, 32'd0, 32'd0, 32'h0000_0001);

        // push into a full FIFO while it pops
        for (int i = 0; i < 4; i++) cons_write(8'h61 + 8'(i), 1'b1);
        bus.console_ready = 1'b1;
        cons_write(8'h50, 1'b1);
        bus.console_ready = 1'b0;
        check("full_push_pop_no_error", {31'd0, bus_error}, 32'd0);
        cycle(32'h0002_0004, 32'd0, 32'd0, 32'h0000_0042);
        bus.console_ready = 1'b1;
        repeat (4) @(posedge cpu_clk);
        #1;
        check("drained_valid_2", {31'd0, bus.console_valid}, 32'd0);
        bus.console_ready = 1'b0;

        // unmapped accesses and error clear/set priority
        cycle(32'h0003_0000, 32'd0, 32'd0, 32'd0);
        check("unmapped_read_error", {31'd0, bus_error}, 32'd1);
        cycle(32'd0, 32'h0002_000C, 32'd0, 32'd0);
        check("error_clear", {31'd0, bus_error}, 32'd0);
        cycle(32'd0, 32'h0001_1000, 32'h0000_0123, 32'd0);
        check("unmapped_write_error", {31'd0, bus_error}, 32'd1);
        cycle(32'h0003_0000, 32'h0002_000C, 32'd0, 32'd0);
        check("set_beats_clear", {31'd0, bus_error}, 32'd1);
        cycle(32'd0, 32'h0002_000C, 32'd0, 32'd0);
        check("error_clear_2", {31'd0, bus_error}, 32'd0);

        // cycle counter load and wrap
        cycle(32'd0, 32'h0002_0008, 32'hFFFF_FFFE, 32'd0);
        cycle(32'h0002_0008, 32'd0, 32'd0, 32'hFFFF_FFFE);
        cycle(32'h0002_0008, 32'd0, 32'd0, 32'hFFFF_FFFF);
        cycle(32'h0002_0008, 32'd0, 32'd0, 32'h0000_0000);

        // reset mid-operation: FIFO holds 2 bytes, LED set; RAM survives
        cons_write(8'h71, 1'b0);
        cons_write(8'h72, 1'b0);
        cycle(32'd0, 32'h0002_0000, 32'h0000_00FF, 32'd0);
        check("leds_ff", leds_reg, 32'h0000_00FF);
        check("fifo_loaded_valid", {31'd0, bus.console_valid}, 32'd1);
        rst = 1'b1;
        @(posedge cpu_clk);
        #1 rst = 1'b0;
        check("reset_console_valid", {31'd0, bus.console_valid}, 32'd0);
        check("reset_leds", leds_reg, 32'd0);
        check("reset_read_data", bus.bus_read_data, 32'd0);
        cycle(32'h0001_0010, 32'd0, 32'd0, 32'hDEAD_BEEF);
        bus.console_ready = 1'b1;
        repeat (2) @(posedge cpu_clk);
        #1 bus.console_ready = 1'b0;

        for (int i = 0; i < 10 && (exp_q.size() != 0 || cons_q.size() != 0); i++)
            @(posedge cpu_clk);
        check("pending_reads", 32'(exp_q.size()), 32'd0);
        check("pending_console", 32'(cons_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
